// File: rtl/pds_responder_if.sv
// Mac SE PDS 68000-style bus bundle between a cycle initiator (master) and a target (slave).
interface pds_responder_if;
  logic        pdsASn;
  logic        pdsUDSn;
  logic        pdsLDSn;
  logic        pdsRnW;
  logic [23:1] pdsA;
  logic [15:0] pdsDIN;
  logic [15:0] pdsDOUT;
  logic        pdsDOE;
  logic        pdsDTACKn;

  modport master (
    output pdsASn, pdsUDSn, pdsLDSn, pdsRnW, pdsA, pdsDIN,
    input  pdsDOUT, pdsDOE, pdsDTACKn
  );

  modport slave (
    input  pdsASn, pdsUDSn, pdsLDSn, pdsRnW, pdsA, pdsDIN,
    output pdsDOUT, pdsDOE, pdsDTACKn
  );
endinterface

// File: rtl/pds_responder.sv
// PDS bus target: decodes a 16-byte register window, inserts C8M wait states and
// terminates with DTACK. Eight 16-bit registers (reg 7 = read-only ID) with byte-lane writes.

module pds_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic pdsC8M,
  input  logic pdsRESET,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] syncPipe;

  always_ff @(posedge pdsC8M or posedge pdsRESET)
    if (pdsRESET) syncPipe <= {STAGES{RST_VAL}};
    else          syncPipe <= {syncPipe[STAGES-2:0], d};

  assign q = syncPipe[STAGES-1];
endmodule

module pds_responder #(
  parameter logic [19:0] BASE        = 20'hFC000,
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] ID_VALUE    = 16'h5E30
) (
  input  logic              pdsC8M,
  input  logic              pdsRESET,
  pds_responder_if.slave    bus,
  output logic [15:0]       ctlOut
);
  localparam int NUM_LANES = 2;
  localparam int VEC_W     = 8;
  localparam logic [2:0] WAIT_INIT = WAIT_STATES[2:0];

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_ACK     = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_IGNORE  = 3'd5;

  logic [2:0] state, nextState;
  logic [2:0] waitCnt, nextCnt;
  logic [2:0] syncQ;
  logic       sAS, sUDS, sLDS;
  logic       hit, enterAck, wrEn;
  logic [2:0] idx;
  logic [NUM_LANES-1:0] laneWe;
  logic [6:0][NUM_LANES-1:0][VEC_W-1:0] regFile;
  logic [7:0][15:0] rdBank;
  logic [15:0] rdData;
  logic [15:0] doutQ;
  logic        doeQ, dtackNQ;

  // One synchronizer per strobe; address, data and RnW are stable while sAS is low.
  pds_sync uSync[2:0] (
    .pdsC8M   (pdsC8M),
    .pdsRESET (pdsRESET),
    .d        ({bus.pdsASn, bus.pdsUDSn, bus.pdsLDSn}),
    .q        (syncQ)
  );
  assign {sAS, sUDS, sLDS} = syncQ;

  assign idx    = bus.pdsA[3:1];
  assign hit    = (bus.pdsA[23:4] == BASE);
  assign laneWe = {~sUDS, ~sLDS};

  always_comb begin
    nextState = state;
    nextCnt   = waitCnt;
    case (state)
      S_IDLE:
        if (!sAS && (bus.pdsRnW || !sUDS || !sLDS)) nextState = S_DECODE;
      S_DECODE:
        if (sAS) nextState = S_IDLE;
        else if (hit) begin
          nextCnt   = WAIT_INIT;
          nextState = (WAIT_INIT == 3'd0) ? S_ACK : S_WAIT;
        end else nextState = S_IGNORE;
      S_WAIT:
        if (sAS) nextState = S_IDLE;
        else begin
          nextCnt = waitCnt - 3'd1;
          if (waitCnt == 3'd1) nextState = S_ACK;
        end
      S_ACK:     if (sAS) nextState = S_RELEASE;
      S_RELEASE: nextState = S_IDLE;
      S_IGNORE:  if (sAS) nextState = S_IDLE;
      default:   nextState = S_IDLE;
    endcase
  end

  // The single ACK-entry edge is both the write commit and the read-data capture point.
  assign enterAck = (nextState == S_ACK) && (state != S_ACK);
  assign wrEn     = enterAck && !bus.pdsRnW && (idx != 3'd7);

  assign rdBank = {ID_VALUE, regFile};
  assign rdData = rdBank[idx];

  always_ff @(posedge pdsC8M or posedge pdsRESET)
    if (pdsRESET) begin
      state   <= S_IDLE;
      waitCnt <= 3'd0;
      dtackNQ <= 1'b1;
      doeQ    <= 1'b0;
      doutQ   <= 16'h0000;
    end else begin
      state   <= nextState;
      waitCnt <= nextCnt;
      dtackNQ <= (nextState != S_ACK);
      if (enterAck)                doeQ <= bus.pdsRnW;
      else if (nextState != S_ACK) doeQ <= 1'b0;
      if (enterAck)                doutQ <= rdData;
    end

  always_ff @(posedge pdsC8M or posedge pdsRESET)
    if (pdsRESET) regFile <= '0;
    else
      for (int r = 0; r < 7; r++)
        for (int l = 0; l < NUM_LANES; l++)
          if (wrEn && idx == 3'(r) && laneWe[l])
            regFile[r][l] <= bus.pdsDIN[l*VEC_W +: VEC_W];

  assign bus.pdsDTACKn = dtackNQ;
  assign bus.pdsDOE    = doeQ;
  assign bus.pdsDOUT   = doutQ;
  assign ctlOut        = regFile[0];
endmodule
